fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request after i_last_grant, with wrap.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [idx_w(NUM_REQ)-1:0]     i_last_grant,
  output logic [idx_w(NUM_REQ)-1:0]     o_idx,
  output logic                          o_any
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0] w_cand;

  // NUM_REQ is a power of two, so the IW-bit sum wraps naturally; k == NUM_REQ revisits last_grant.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = i_last_grant + IW'(k);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting one producer at a time bursts of up to MAX_BURST words
// into a shared FIFO write port. Handshake: a word moves when req_valid[i] && req_ready[i].
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_request,
  output logic [DATA_W-1:0]             fifo_write_data,
  output logic [idx_w(NUM_REQ)-1:0]     grant_id,
  output logic                          busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_grant_id, w_grant_nxt;
  logic [IW-1:0] r_last_grant, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic          w_owner_valid;
  logic          w_ready;
  logic          w_xfer;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_idx        (w_pick_idx),
    .o_any        (w_pick_any)
  );

  // rst gates the strobe so a reset landing mid-burst never commits a word.
  assign w_owner_valid = req_valid[r_grant_id];
  assign w_ready       = (r_state == ST_GRANT) && clk_en && !fifo_full && !rst;
  assign w_xfer        = w_ready && w_owner_valid;

  always_comb begin
    req_ready             = '0;
    req_ready[r_grant_id] = w_ready;
  end

  assign fifo_write_request = w_xfer;
  assign fifo_write_data    = req_data[int'(r_grant_id)*DATA_W +: DATA_W];
  assign grant_id           = r_grant_id;
  assign busy               = (r_state == ST_GRANT);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_cnt;
    if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            w_state_nxt = ST_GRANT;
            w_grant_nxt = w_pick_idx;
          end
        end
        ST_GRANT: begin
          // Full stalls leave w_xfer low, so the counter only moves on real transfers.
          if (!w_owner_valid || (w_xfer && r_cnt == CW'(MAX_BURST - 1))) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_grant_id;
            w_cnt_nxt   = '0;
          end else if (w_xfer) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: producer models feed the DUT, a scoreboard
// holds hand-computed {grant, data, cycle} entries and a monitor checks every write.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int EW = 2 + DW + 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_en;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_write_request;
  logic [DW-1:0]    fifo_write_data;
  logic [1:0]       grant_id;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  logic [NR-1:0]  en;
  logic [DW-1:0]  src_mem [NR][32];
  int             src_hd [NR];
  int             src_tl [NR];
  logic [EW-1:0]  exp_q[$];

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk                (clk),
    .rst                (rst),
    .clk_en             (clk_en),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_ready          (req_ready),
    .fifo_full          (fifo_full),
    .fifo_write_request (fifo_write_request),
    .fifo_write_data    (fifo_write_data),
    .grant_id           (grant_id),
    .busy               (busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (fifo_write_request === 1'b1) begin
      checks++;
      a = {grant_id, fifo_write_data, 16'(cyc - base)};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write act id=%0d data=%0h rel=%0d exp none",
                 grant_id, fifo_write_data, cyc - base);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL write act id=%0d data=%0h rel=%0d exp id=%0d data=%0h rel=%0d",
                   a[EW-1 -: 2], a[DW+15:16], a[15:0], e[EW-1 -: 2], e[DW+15:16], e[15:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp_v);
    end
  endtask

  task automatic exp_push(input int id, input logic [DW-1:0] d, input int rel);
    exp_q.push_back({2'(id), d, 16'(rel)});
  endtask

  task automatic push_src(input int i, input logic [DW-1:0] d);
    src_mem[i][src_tl[i]] = d;
    src_tl[i]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (src_hd[i] < src_tl[i]);
      req_data[i*DW +: DW] = (src_hd[i] < 32) ? src_mem[i][src_hd[i]] : '0;
    end
  endtask

  task automatic settle();
    drive_inputs();
    #1;
  endtask

  task automatic start_test();
    drive_inputs();
    base = cyc;
    #1;
  endtask

  // one clock: note accepts before the edge, retire them after it
  task automatic step();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i]) src_hd[i]++;
    settle();
  endtask

  task automatic wait_rel(input int n);
    while (cyc - base < n) step();
  endtask

  // reset held with clk_en low: reset must win over the enable
  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    fifo_full = 1'b0;
    en = '0;
    for (int i = 0; i < NR; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end
    settle();
    step();
    step();
    rst = 1'b0;
    clk_en = 1'b1;
    settle();
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_write", fifo_write_request, 0);

    // A: single producer, burst of 8 then bubble then remainder
    for (int k = 0; k < 12; k++) push_src(0, DW'(32'h100 + k));
    en = 4'b0001;
    start_test();
    for (int k = 0; k < 8; k++) exp_push(0, DW'(32'h100 + k), 1 + k);
    for (int k = 8; k < 12; k++) exp_push(0, DW'(32'h100 + k), 10 + k - 8);
    chk("A_idle_ready", req_ready, 0);
    wait_rel(1);
    chk("A_grant", grant_id, 0);
    chk("A_ready", req_ready, 4'b0001);
    chk("A_busy", busy, 1);
    wait_rel(9);
    chk("A_bubble_busy", busy, 0);
    chk("A_bubble_ready", req_ready, 0);
    wait_rel(15);
    chk("A_drain", exp_q.size(), 0);
    chk("A_end_busy", busy, 0);

    // B: all four valid, round-robin 0,1,2,3 of 8 each, then leftovers
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 9; k++) push_src(i, DW'(32'hB000 + i*256 + k));
    en = 4'b1111;
    start_test();
    for (int g = 0; g < NR; g++)
      for (int k = 0; k < 8; k++) exp_push(g, DW'(32'hB000 + g*256 + k), 1 + g*9 + k);
    for (int i = 0; i < NR; i++) exp_push(i, DW'(32'hB000 + i*256 + 8), 37 + 3*i);
    wait_rel(10);
    chk("B_grant1", grant_id, 1);
    wait_rel(19);
    chk("B_grant2", grant_id, 2);
    wait_rel(28);
    chk("B_grant3", grant_id, 3);
    wait_rel(37);
    chk("B_grant0_again", grant_id, 0);
    wait_rel(48);
    chk("B_drain", exp_q.size(), 0);
    chk("B_end_busy", busy, 0);

    // C: fifo_full for 5 cycles after 3 transfers
    do_reset();
    for (int k = 0; k < 10; k++) push_src(0, DW'(32'hC00 + k));
    en = 4'b0001;
    start_test();
    for (int k = 0; k < 3; k++) exp_push(0, DW'(32'hC00 + k), 1 + k);
    for (int k = 3; k < 8; k++) exp_push(0, DW'(32'hC00 + k), 9 + k - 3);
    exp_push(0, DW'(32'hC08), 15);
    exp_push(0, DW'(32'hC09), 16);
    wait_rel(4);
    fifo_full = 1'b1;
    settle();
    chk("C_full_ready", req_ready, 0);
    chk("C_full_write", fifo_write_request, 0);
    chk("C_full_busy", busy, 1);
    wait_rel(8);
    chk("C_full_grant", grant_id, 0);
    chk("C_full_busy_end", busy, 1);
    wait_rel(9);
    fifo_full = 1'b0;
    settle();
    wait_rel(18);
    chk("C_drain", exp_q.size(), 0);

    // D: owner 1 drops valid after 2 words, 0110 pending -> grant 2
    do_reset();
    push_src(1, DW'(32'hD10));
    push_src(1, DW'(32'hD11));
    for (int k = 0; k < 3; k++) push_src(2, DW'(32'hD20 + k));
    en = 4'b0110;
    start_test();
    exp_push(1, DW'(32'hD10), 1);
    exp_push(1, DW'(32'hD11), 2);
    for (int k = 0; k < 3; k++) exp_push(2, DW'(32'hD20 + k), 5 + k);
    exp_push(1, DW'(32'hD12), 10);
    exp_push(1, DW'(32'hD13), 11);
    wait_rel(3);
    chk("D_drop_grant", grant_id, 1);
    chk("D_drop_ready", req_ready, 4'b0010);
    wait_rel(4);
    chk("D_release_busy", busy, 0);
    push_src(1, DW'(32'hD12));
    push_src(1, DW'(32'hD13));
    settle();
    wait_rel(5);
    chk("D_next_grant", grant_id, 2);
    wait_rel(10);
    chk("D_back_to_1", grant_id, 1);
    wait_rel(13);
    chk("D_drain", exp_q.size(), 0);

    // E: clk_en low for 3 cycles mid-burst
    do_reset();
    for (int k = 0; k < 10; k++) push_src(0, DW'(32'hE00 + k));
    en = 4'b0001;
    start_test();
    exp_push(0, DW'(32'hE00), 1);
    exp_push(0, DW'(32'hE01), 2);
    for (int k = 2; k < 8; k++) exp_push(0, DW'(32'hE00 + k), 6 + k - 2);
    exp_push(0, DW'(32'hE08), 13);
    exp_push(0, DW'(32'hE09), 14);
    wait_rel(3);
    clk_en = 1'b0;
    settle();
    chk("E_hold_ready", req_ready, 0);
    chk("E_hold_write", fifo_write_request, 0);
    wait_rel(5);
    chk("E_hold_grant", grant_id, 0);
    chk("E_hold_busy", busy, 1);
    wait_rel(6);
    clk_en = 1'b1;
    settle();
    wait_rel(16);
    chk("E_drain", exp_q.size(), 0);

    // F: rst after 4 transfers of grant 2
    do_reset();
    for (int k = 0; k < 8; k++) push_src(2, DW'(32'hF20 + k));
    push_src(0, DW'(32'hF00));
    push_src(0, DW'(32'hF01));
    en = 4'b0100;
    start_test();
    for (int k = 0; k < 4; k++) exp_push(2, DW'(32'hF20 + k), 1 + k);
    exp_push(0, DW'(32'hF00), 7);
    exp_push(0, DW'(32'hF01), 8);
    for (int k = 4; k < 8; k++) exp_push(2, DW'(32'hF20 + k), 11 + k - 4);
    wait_rel(1);
    chk("F_grant2", grant_id, 2);
    wait_rel(5);
    rst = 1'b1;
    en = 4'b0101;
    settle();
    chk("F_rst_write", fifo_write_request, 0);
    chk("F_rst_ready", req_ready, 0);
    wait_rel(6);
    rst = 1'b0;
    settle();
    chk("F_after_rst_busy", busy, 0);
    wait_rel(7);
    chk("F_next_grant0", grant_id, 0);
    wait_rel(11);
    chk("F_regrant2", grant_id, 2);
    wait_rel(16);
    chk("F_drain", exp_q.size(), 0);
    chk("F_end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
